// File: rtl/systolic_os_engine.sv
// rtl/systolic_os_engine.sv - output-stationary systolic tile engine with operand skew, flush and row drain
// Define SYSTOLIC_OS_SAT_EN for saturating accumulation; the default build wraps modulo 2^ACC_W.
module systolic_os_engine #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 256,
  parameter int KW     = $clog2(K_MAX + 1),
  parameter int RW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             cfg_k,
  input  logic                      cfg_accum,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_ROWS*DATA_W-1:0]  in_a,
  input  logic [N_COLS*DATA_W-1:0]  in_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [N_COLS*ACC_W-1:0]   res_data,
  output logic [RW-1:0]             res_row,
  output logic                      res_last,
  output logic                      busy,
  output logic                      done
);

  localparam int PW        = 2 * DATA_W;
  localparam int FLUSH_LEN = N_ROWS + N_COLS - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] k_cfg;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          accept;
  logic          clear_acc;

  assign accept    = in_valid & in_ready;
  assign clear_acc = (state == IDLE) & start & ~cfg_accum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      k_cfg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            k_cfg    <= cfg_k;
            beat_cnt <= '0;
            if (cfg_k != '0) begin
              state    <= STREAM;
              in_ready <= 1'b1;
            end else begin
              state     <= DRAIN;
              res_valid <= 1'b1;
              res_row   <= '0;
              res_last  <= (N_ROWS == 1);
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_cfg) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          // Wait until the last beat has reached the far corner PE.
          if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
            state     <= DRAIN;
            res_valid <= 1'b1;
            res_row   <= '0;
            res_last  <= (N_ROWS == 1);
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (res_last) begin
              state     <= IDLE;
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              res_row   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              res_row  <= res_row + RW'(1);
              res_last <= (res_row == RW'(N_ROWS - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bubble cycles and non-STREAM states feed zeros into the array.
  logic [N_ROWS*DATA_W-1:0] a_src;
  logic [N_COLS*DATA_W-1:0] b_src;
  logic [N_ROWS*DATA_W-1:0] a_feed;
  logic [N_COLS*DATA_W-1:0] b_feed;

  assign a_src = accept ? in_a : '0;
  assign b_src = accept ? in_b : '0;

  for (genvar r = 0; r < N_ROWS; r++) begin : g_skew_a
    if (r == 0) begin : g_direct
      assign a_feed[DATA_W-1:0] = a_src[DATA_W-1:0];
    end else begin : g_delay
      logic [DATA_W-1:0] dl [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) dl[i] <= '0;
        end else begin
          dl[0] <= a_src[r*DATA_W +: DATA_W];
          for (int i = 1; i < r; i++) dl[i] <= dl[i-1];
        end
      end
      assign a_feed[r*DATA_W +: DATA_W] = dl[r-1];
    end
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_skew_b
    if (c == 0) begin : g_direct
      assign b_feed[DATA_W-1:0] = b_src[DATA_W-1:0];
    end else begin : g_delay
      logic [DATA_W-1:0] dl [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) dl[i] <= '0;
        end else begin
          dl[0] <= b_src[c*DATA_W +: DATA_W];
          for (int i = 1; i < c; i++) dl[i] <= dl[i-1];
        end
      end
      assign b_feed[c*DATA_W +: DATA_W] = dl[c-1];
    end
  end

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] acc_in,
                                                  input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] term;
`ifdef SYSTOLIC_OS_SAT_EN
    logic [ACC_W:0]          sum;
`endif
    prod = PW'(a) * PW'(b);
    term = ACC_W'(prod);
`ifdef SYSTOLIC_OS_SAT_EN
    sum = {acc_in[ACC_W-1], acc_in} + {term[ACC_W-1], term};
    if (sum[ACC_W] != sum[ACC_W-1])
      mac = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      mac = sum[ACC_W-1:0];
`else
    mac = acc_in + term;
`endif
  endfunction

  logic signed [DATA_W-1:0] a_pipe [N_ROWS][N_COLS];
  logic signed [DATA_W-1:0] b_pipe [N_ROWS][N_COLS];
  logic signed [ACC_W-1:0]  acc    [N_ROWS][N_COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          acc[r][c]    <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_ROWS; r++) begin
        a_pipe[r][0] <= a_feed[r*DATA_W +: DATA_W];
        for (int c = 1; c < N_COLS; c++) a_pipe[r][c] <= a_pipe[r][c-1];
      end
      for (int c = 0; c < N_COLS; c++) begin
        b_pipe[0][c] <= b_feed[c*DATA_W +: DATA_W];
        for (int r = 1; r < N_ROWS; r++) b_pipe[r][c] <= b_pipe[r-1][c];
      end
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if (clear_acc) acc[r][c] <= '0;
          else           acc[r][c] <= mac(acc[r][c], a_pipe[r][c], b_pipe[r][c]);
        end
      end
    end
  end

  // Accumulators are frozen during DRAIN, so the row mux is stable under stall.
  always_comb begin
    res_data = '0;
    for (int c = 0; c < N_COLS; c++) res_data[c*ACC_W +: ACC_W] = acc[res_row][c];
  end

endmodule
